wb_stage: RTL and testbench

Write-back stage between the data-memory stage and the register file. Accepts one retiring instruction per handshake and waits for load data where needed. Aligns and sign-extends the load data and selects the write-back source. Drives the register-file write port (Write, WriteReg, WriteData) from registered outputs and exposes the same values for forwarding.

---
 rtl/wb_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//
// Write-back stage sitting between the data-memory stage and the register
// file. Accepts one retiring instruction per handshake, waits for load data
// when the instruction is a load, aligns and sign/zero-extends that data,
// selects the write-back source and drives the register-file write port from
// registered outputs. The same registered values serve as the forwarding
// source for earlier pipeline stages.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   -> retire_cnt port and counter present
//   undefined -> port and counter absent, all other behaviour identical
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset (0 = reset)
//   m_valid        upstream holds a valid instruction
//   wb_ready       stage can accept (high only in IDLE)
//   flush          kill the pending instruction
//   m_reg_write    instruction writes rd
//   m_rd           destination register
//   m_wb_sel       source select: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
//   m_funct3       load size/sign
//   m_addr_lo      low two bits of the load address
//   m_alu_result   ALU result
//   m_pc_plus4     PC+4
//   m_imm          immediate (lui)
//   dmem_rvalid    load data valid this cycle
//   dmem_rdata     raw memory word
//   Write          register-file write enable, one-cycle pulse per retire
//   WriteReg       register-file write address
//   WriteData      register-file write data
//   retire_cnt     retired-instruction count (WB_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module wb_stage #(
   parameter int XLEN     = 32,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m_valid,
   output logic                wb_ready,
   input  logic                flush,
   input  logic                m_reg_write,
   input  logic [4:0]          m_rd,
   input  logic [1:0]          m_wb_sel,
   input  logic [2:0]          m_funct3,
   input  logic [1:0]          m_addr_lo,
   input  logic [XLEN-1:0]     m_alu_result,
   input  logic [XLEN-1:0]     m_pc_plus4,
   input  logic [XLEN-1:0]     m_imm,
   input  logic                dmem_rvalid,
   input  logic [31:0]         dmem_rdata,
   output logic                Write,
   output logic [4:0]          WriteReg,
   output logic [XLEN-1:0]     WriteData
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [RETIRE_W-1:0] retire_cnt
`endif
);

   // state    | meaning
   // ---------+--------------------------------------------------------------
   // IDLE     | ready for a new instruction; non-loads retire on acceptance
   // WAIT_MEM | load accepted, waiting for dmem_rvalid (or flush)
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_WAIT_MEM = 1'b1;

   localparam logic [1:0] SEL_ALU = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_PC4 = 2'd2;
   localparam logic [1:0] SEL_IMM = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [0:0]      state_q,      state_d;
   logic            reg_write_q,  reg_write_d;
   logic [4:0]      rd_q,         rd_d;
   logic [1:0]      wb_sel_q,     wb_sel_d;
   logic [2:0]      funct3_q,     funct3_d;
   logic [1:0]      addr_lo_q,    addr_lo_d;
   logic [XLEN-1:0] alu_q,        alu_d;
   logic [XLEN-1:0] pc4_q,        pc4_d;
   logic [XLEN-1:0] imm_q,        imm_d;
   logic            write_q,      write_d;
   logic [4:0]      write_reg_q,  write_reg_d;
   logic [XLEN-1:0] write_data_q, write_data_d;

   logic            retire;
   logic [XLEN-1:0] load_data;

   // Little-endian extraction. addr_lo[0] is deliberately ignored for
   // halfwords: misaligned halfword loads are not trapped here.
   function automatic logic [XLEN-1:0] align_load(input logic [2:0]  f3,
                                                  input logic [1:0]  alo,
                                                  input logic [31:0] word);
      logic [7:0]      byte_v;
      logic [15:0]     half_v;
      logic [XLEN-1:0] res;
      case (alo)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = alo[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_LB:   res = XLEN'($signed(byte_v));
         F3_LBU:  res = XLEN'(byte_v);
         F3_LH:   res = XLEN'($signed(half_v));
         F3_LHU:  res = XLEN'(half_v);
         default: res = XLEN'($signed(word));
      endcase
      return res;
   endfunction

   function automatic logic [XLEN-1:0] wb_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] alu,
                                              input logic [XLEN-1:0] mem,
                                              input logic [XLEN-1:0] pc4,
                                              input logic [XLEN-1:0] imm);
      logic [XLEN-1:0] res;
      case (sel)
         SEL_ALU: res = alu;
         SEL_MEM: res = mem;
         SEL_PC4: res = pc4;
         default: res = imm;
      endcase
      return res;
   endfunction

   // Load data always comes from the captured size/offset: loads never
   // retire in the same cycle they are accepted.
   assign load_data = align_load(funct3_q, addr_lo_q, dmem_rdata);
   assign wb_ready  = (state_q == ST_IDLE);

   always_comb begin
      state_d      = state_q;
      reg_write_d  = reg_write_q;
      rd_d         = rd_q;
      wb_sel_d     = wb_sel_q;
      funct3_d     = funct3_q;
      addr_lo_d    = addr_lo_q;
      alu_d        = alu_q;
      pc4_d        = pc4_q;
      imm_d        = imm_q;
      write_d      = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      retire       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (m_valid && wb_ready && !flush) begin
               reg_write_d = m_reg_write;
               rd_d        = m_rd;
               wb_sel_d    = m_wb_sel;
               funct3_d    = m_funct3;
               addr_lo_d   = m_addr_lo;
               alu_d       = m_alu_result;
               pc4_d       = m_pc_plus4;
               imm_d       = m_imm;
               if (m_wb_sel == SEL_MEM) begin
                  state_d = ST_WAIT_MEM;
               end else begin
                  // Retire straight from the inputs so the result is on
                  // the write port in the very next cycle.
                  retire  = 1'b1;
                  write_d = m_reg_write && (m_rd != 5'd0);
                  if (write_d) begin
                     write_reg_d  = m_rd;
                     write_data_d = wb_mux(m_wb_sel, m_alu_result, load_data,
                                           m_pc_plus4, m_imm);
                  end
               end
            end
         end
         ST_WAIT_MEM: begin
            // Flush wins over a coincident rvalid; that data is dropped.
            if (flush) begin
               state_d = ST_IDLE;
            end else if (dmem_rvalid) begin
               state_d = ST_IDLE;
               retire  = 1'b1;
               write_d = reg_write_q && (rd_q != 5'd0);
               if (write_d) begin
                  write_reg_d  = rd_q;
                  write_data_d = wb_mux(wb_sel_q, alu_q, load_data, pc4_q, imm_q);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         reg_write_q  <= 1'b0;
         rd_q         <= 5'd0;
         wb_sel_q     <= 2'd0;
         funct3_q     <= 3'd0;
         addr_lo_q    <= 2'd0;
         alu_q        <= '0;
         pc4_q        <= '0;
         imm_q        <= '0;
         write_q      <= 1'b0;
         write_reg_q  <= 5'd0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         reg_write_q  <= reg_write_d;
         rd_q         <= rd_d;
         wb_sel_q     <= wb_sel_d;
         funct3_q     <= funct3_d;
         addr_lo_q    <= addr_lo_d;
         alu_q        <= alu_d;
         pc4_q        <= pc4_d;
         imm_q        <= imm_d;
         write_q      <= write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign Write     = write_q;
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;

`ifdef WB_RETIRE_CNT_EN
   // Counts every retire, including those suppressed by rd==0 or
   // reg_write==0. Wraps naturally at all-ones.
   logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (retire) begin
         retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

`ifdef WB_RETIRE_CNT_EN
   localparam int RW = 4;
`else
   localparam int RW = 32;
`endif

   logic        clk;
   logic        rst;
   logic        m_valid;
   logic        wb_ready;
   logic        flush;
   logic        m_reg_write;
   logic [4:0]  m_rd;
   logic [1:0]  m_wb_sel;
   logic [2:0]  m_funct3;
   logic [1:0]  m_addr_lo;
   logic [31:0] m_alu_result;
   logic [31:0] m_pc_plus4;
   logic [31:0] m_imm;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        Write;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
`ifdef WB_RETIRE_CNT_EN
   logic [RW-1:0] retire_cnt;
`endif

   wb_stage #(.XLEN(32), .RETIRE_W(RW)) dut (
      .clk          (clk),
      .rst          (rst),
      .m_valid      (m_valid),
      .wb_ready     (wb_ready),
      .flush        (flush),
      .m_reg_write  (m_reg_write),
      .m_rd         (m_rd),
      .m_wb_sel     (m_wb_sel),
      .m_funct3     (m_funct3),
      .m_addr_lo    (m_addr_lo),
      .m_alu_result (m_alu_result),
      .m_pc_plus4   (m_pc_plus4),
      .m_imm        (m_imm),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .Write        (Write),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt   (retire_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          tests = 0;
   int          fails = 0;
   logic [36:0] exp_q[$];
   logic [31:0] exp_cnt = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input string name);
`ifdef WB_RETIRE_CNT_EN
      chk(name, 32'(retire_cnt), exp_cnt % (32'd1 << RW));
`endif
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back({rd, data});
   endtask

   // Scoreboard monitor: every Write pulse must match the oldest expectation.
   initial begin
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && Write === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got reg %0d data 0x%08h required no write",
                        WriteReg, WriteData);
            end else begin
               e = exp_q.pop_front();
               chk("wr_reg", {27'd0, WriteReg}, {27'd0, e[36:32]});
               chk("wr_data", WriteData, e[31:0]);
            end
         end
      end
   end

   // Drives one instruction for exactly one cycle; the stage must be idle.
   // Unselected sources carry distinct junk so a wrong mux choice shows up.
   task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] val);
      m_reg_write  = rw;
      m_rd         = rd;
      m_wb_sel     = sel;
      m_funct3     = f3;
      m_addr_lo    = alo;
      m_alu_result = (sel == 2'd0) ? val : 32'h1111_1111;
      m_pc_plus4   = (sel == 2'd2) ? val : 32'h2222_2222;
      m_imm        = (sel == 2'd3) ? val : 32'h3333_3333;
      m_valid      = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [1:0] alo, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp);
      expect_wr(rd, exp);
      exp_cnt++;
      issue(1'b1, rd, 2'd1, f3, alo, 32'h0);
      @(negedge clk);
      chk("ld_wait1_ready", {31'd0, wb_ready}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ld_wait2_ready", {31'd0, wb_ready}, 32'd0);
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ld_done_ready", {31'd0, wb_ready}, 32'd1);
      chk("ld_write", {31'd0, Write}, 32'd1);
   endtask

   initial begin
      rst          = 1'b0;
      m_valid      = 1'b0;
      flush        = 1'b0;
      m_reg_write  = 1'b0;
      m_rd         = 5'd0;
      m_wb_sel     = 2'd0;
      m_funct3     = 3'd0;
      m_addr_lo    = 2'd0;
      m_alu_result = 32'd0;
      m_pc_plus4   = 32'd0;
      m_imm        = 32'd0;
      dmem_rvalid  = 1'b0;
      dmem_rdata   = 32'd0;

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_write", {31'd0, Write}, 32'd0);
      chk("rst_wreg", {27'd0, WriteReg}, 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_ready", {31'd0, wb_ready}, 32'd1);
      chk_cnt("rst_cnt");
      @(posedge clk);
      #1;

      // ALU write, then pulse must drop
      expect_wr(5'd5, 32'h0000_1234);
      exp_cnt++;
      issue(1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h0000_1234);
      @(negedge clk);
      chk("alu_write", {31'd0, Write}, 32'd1);
      chk_cnt("alu_cnt");
      @(negedge clk);
      chk("alu_pulse_end", {31'd0, Write}, 32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of WAIT_MEM abandons the load
      issue(1'b1, 5'd6, 2'd1, 3'd2, 2'd0, 32'h0);
      @(negedge clk);
      chk("mid_wait_ready", {31'd0, wb_ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_cnt = 32'd0;
      @(negedge clk);
      chk("mrst_write", {31'd0, Write}, 32'd0);
      chk("mrst_wreg", {27'd0, WriteReg}, 32'd0);
      chk("mrst_wdata", WriteData, 32'd0);
      chk("mrst_ready", {31'd0, wb_ready}, 32'd1);
      chk_cnt("mrst_cnt");
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("mrst_late_rvalid", {31'd0, Write}, 32'd0);
      @(posedge clk);
      #1;

      // Load alignment vectors
      do_load(3'b000, 2'd3, 5'd10, 32'h80FF_0000, 32'hFFFF_FF80);
      do_load(3'b101, 2'd2, 5'd11, 32'h80FF_0000, 32'h0000_80FF);
      do_load(3'b001, 2'd1, 5'd12, 32'h0000_8001, 32'hFFFF_8001);
      do_load(3'b100, 2'd1, 5'd13, 32'h0000_AB00, 32'h0000_00AB);
      do_load(3'b010, 2'd0, 5'd14, 32'h1234_5678, 32'h1234_5678);
      do_load(3'b011, 2'd2, 5'd15, 32'hCAFE_F00D, 32'hCAFE_F00D);
      chk_cnt("load_cnt");
      @(posedge clk);
      #1;

      // IMM source
      expect_wr(5'd4, 32'hDEAD_B000);
      exp_cnt++;
      issue(1'b1, 5'd4, 2'd3, 3'd0, 2'd0, 32'hDEAD_B000);
      @(negedge clk);
      chk("imm_write", {31'd0, Write}, 32'd1);
      @(posedge clk);
      #1;

      // rd0 and reg_write=0: retire without writing
      issue(1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0000_0055);
      issue(1'b0, 5'd7, 2'd0, 3'd0, 2'd0, 32'h0000_0077);
      exp_cnt = exp_cnt + 32'd2;
      @(negedge clk);
      chk("nowr_write", {31'd0, Write}, 32'd0);
      chk_cnt("nowr_cnt");
      @(posedge clk);
      #1;

      // Flush together with rvalid in WAIT_MEM
      issue(1'b1, 5'd8, 2'd1, 3'd2, 2'd0, 32'h0);
      flush       = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      dmem_rvalid = 1'b0;
      @(negedge clk);
      chk("flush_ready", {31'd0, wb_ready}, 32'd1);
      chk("flush_write", {31'd0, Write}, 32'd0);
      chk_cnt("flush_cnt");
      @(posedge clk);
      #1;

      // Flush in IDLE blocks acceptance
      m_reg_write  = 1'b1;
      m_rd         = 5'd9;
      m_wb_sel     = 2'd0;
      m_alu_result = 32'h0000_0099;
      m_valid      = 1'b1;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      flush   = 1'b0;
      @(negedge clk);
      chk("iflush_write", {31'd0, Write}, 32'd0);
      chk("iflush_ready", {31'd0, wb_ready}, 32'd1);
      chk_cnt("iflush_cnt");
      @(posedge clk);
      #1;

      // Back-to-back PC+4 retires
      expect_wr(5'd1, 32'h0000_0010);
      expect_wr(5'd2, 32'h0000_0014);
      expect_wr(5'd3, 32'h0000_0018);
      exp_cnt = exp_cnt + 32'd3;
      issue(1'b1, 5'd1, 2'd2, 3'd0, 2'd0, 32'h0000_0010);
      chk("b2b_w1", {31'd0, Write}, 32'd1);
      issue(1'b1, 5'd2, 2'd2, 3'd0, 2'd0, 32'h0000_0014);
      chk("b2b_w2", {31'd0, Write}, 32'd1);
      issue(1'b1, 5'd3, 2'd2, 3'd0, 2'd0, 32'h0000_0018);
      chk("b2b_w3", {31'd0, Write}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_end", {31'd0, Write}, 32'd0);
      chk_cnt("b2b_cnt");
      @(posedge clk);
      #1;

      // More ALU retires carry a 4-bit counter through its wrap
      for (int i = 0; i < 5; i++) begin
         expect_wr(5'(20 + i), 32'h0000_0100 * 32'(i + 1));
         exp_cnt++;
         issue(1'b1, 5'(20 + i), 2'd0, 3'd0, 2'd0, 32'h0000_0100 * 32'(i + 1));
         @(negedge clk);
         chk_cnt("loop_cnt");
         @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
